// File: rtl/sb_dsp_reset_responder.sv
// Emulated DSP reset/response port block: a reset pulse on BASE+6 makes 0xAA readable on BASE+A.
// Optional minimum-pulse-width check enabled by defining DSP_PULSE_CHECK_EN.
module sb_dsp_reset_responder #(
    parameter logic [15:0] BASE_ADDRESS      = 16'h0000,
    parameter int unsigned MIN_PULSE_CYCLES  = 24,
    parameter int unsigned RESP_DELAY_CYCLES = 4
) (
    input  logic        bus_clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [15:0] data_out,
    output logic        data_out_valid,
    output logic        dsp_ready,
    output logic        pulse_err
);

    localparam logic [15:0] ResetAddr  = BASE_ADDRESS + 16'h0006;
    localparam logic [15:0] ReadAddr   = BASE_ADDRESS + 16'h000A;
    localparam logic [15:0] StatusAddr = BASE_ADDRESS + 16'h000E;

    localparam logic [15:0] StatusReady = 16'h0080;
    localparam logic [15:0] ReadyByte   = 16'h00AA;

    // A zero delay is treated as a single RESP_WAIT cycle.
    localparam int unsigned DlyW = (RESP_DELAY_CYCLES > 1) ? $clog2(RESP_DELAY_CYCLES) : 1;
    localparam logic [DlyW-1:0] DlyLast =
        DlyW'((RESP_DELAY_CYCLES > 0) ? RESP_DELAY_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StResetHeld,
        StRespWait,
        StDataReady,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [DlyW-1:0]   dly_cnt_q, dly_cnt_d;
    logic [15:0]       data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;

    logic              wr_reset;
    logic              set_cmd;
    logic              clr_cmd;
    logic              rd_ok;
    logic              rd_status;
    logic              rd_data;
    logic              unused_data;

    assign unused_data = ^data_in[15:1];

    // Bus decode; a write in the same cycle always wins over a read.
    assign wr_reset  = wr_en && (address == ResetAddr);
    assign set_cmd   = wr_reset && data_in[0];
    assign clr_cmd   = wr_reset && !data_in[0];
    assign rd_ok     = rd_en && !wr_en;
    assign rd_status = rd_ok && (address == StatusAddr);
    assign rd_data   = rd_ok && (address == ReadAddr);

`ifdef DSP_PULSE_CHECK_EN
    localparam int unsigned PulseW = (MIN_PULSE_CYCLES > 0) ? $clog2(MIN_PULSE_CYCLES + 1) : 1;
    localparam logic [PulseW-1:0] PulseMax = PulseW'(MIN_PULSE_CYCLES);

    logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic              pulse_err_q, pulse_err_d;

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (set_cmd) begin
            pulse_cnt_d = '0;
        end else if ((state_q == StResetHeld) && (pulse_cnt_q != PulseMax)) begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge bus_clock) begin
        if (reset) begin
            pulse_cnt_q <= '0;
            pulse_err_q <= 1'b0;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
            pulse_err_q <= pulse_err_d;
        end
    end

    assign pulse_err = pulse_err_q;
`else
    assign pulse_err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
`ifdef DSP_PULSE_CHECK_EN
        pulse_err_d = pulse_err_q;
`endif
        case (state_q)
            StResetHeld: begin
                if (clr_cmd) begin
`ifdef DSP_PULSE_CHECK_EN
                    if (pulse_cnt_q == PulseMax) begin
                        state_d     = StRespWait;
                        dly_cnt_d   = '0;
                        pulse_err_d = 1'b0;
                    end else begin
                        state_d     = StIdle;
                        pulse_err_d = 1'b1;
                    end
`else
                    state_d   = StRespWait;
                    dly_cnt_d = '0;
`endif
                end
            end
            StRespWait: begin
                if (dly_cnt_q == DlyLast) begin
                    state_d = StDataReady;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            StDataReady: begin
                if (rd_data) begin
                    state_d = StReady;
                end
            end
            default: ;
        endcase

        // Asserting DSP reset restarts the handshake from any state.
        if (set_cmd) begin
            state_d = StResetHeld;
        end
    end

    // Registered read response, based on the state seen when rd_en was sampled
    always_comb begin
        data_out_d = '0;
        valid_d    = 1'b0;
        if (rd_status) begin
            valid_d    = 1'b1;
            data_out_d = (state_q == StDataReady) ? StatusReady : 16'h0000;
        end else if (rd_data) begin
            valid_d    = 1'b1;
            data_out_d = ((state_q == StDataReady) || (state_q == StReady)) ? ReadyByte : 16'h0000;
        end
        ready_d = (state_d == StDataReady);
    end

    always_ff @(posedge bus_clock) begin
        if (reset) begin
            state_q    <= StIdle;
            dly_cnt_q  <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign dsp_ready      = ready_q;

endmodule

// File: tb/tb_sb_dsp_reset_responder.sv
// Directed bench for sb_dsp_reset_responder; a second instance covers a non-zero base address.
module tb_sb_dsp_reset_responder;

    logic        bus_clock;
    logic        reset;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;

    logic [15:0] data_out,  data_out2;
    logic        valid,     valid2;
    logic        dsp_ready, dsp_ready2;
    logic        pulse_err, pulse_err2;

    int n_checks = 0;
    int n_errors = 0;

    sb_dsp_reset_responder dut (
        .bus_clock      (bus_clock),
        .reset          (reset),
        .address        (address),
        .data_in        (data_in),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .data_out_valid (valid),
        .dsp_ready      (dsp_ready),
        .pulse_err      (pulse_err)
    );

    sb_dsp_reset_responder #(
        .BASE_ADDRESS (16'h0220)
    ) dut2 (
        .bus_clock      (bus_clock),
        .reset          (reset),
        .address        (address),
        .data_in        (data_in),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .data_out       (data_out2),
        .data_out_valid (valid2),
        .dsp_ready      (dsp_ready2),
        .pulse_err      (pulse_err2)
    );

    initial bus_clock = 1'b0;
    always #5 bus_clock = ~bus_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge bus_clock);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        data_in = d;
        wr_en   = 1'b1;
        idle(1);
        wr_en   = 1'b0;
    endtask

    // Outputs reflect the read as soon as this returns.
    task automatic rd(input logic [15:0] a);
        address = a;
        rd_en   = 1'b1;
        idle(1);
        rd_en   = 1'b0;
    endtask

    task automatic full_pulse(input logic [15:0] a);
        wr(a, 16'h0001);
        idle(30);
        wr(a, 16'h0000);
        idle(4);
    endtask

    initial begin
        reset   = 1'b1;
        address = '0;
        data_in = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        idle(3);
        check("rst data_out", data_out, 0);
        check("rst valid", valid, 0);
        check("rst dsp_ready", dsp_ready, 0);
        check("rst pulse_err", pulse_err, 0);
        reset = 1'b0;

        rd(16'h000E);
        check("idle status data", data_out, 16'h0000);
        check("idle status valid", valid, 1);
        rd(16'h000A);
        check("idle read data", data_out, 16'h0000);
        check("idle read valid", valid, 1);

        // Full handshake
        wr(16'h0006, 16'h0001);
        idle(30);
        wr(16'h0006, 16'h0000);
        idle(3);
        check("ready before delay", dsp_ready, 0);
        idle(1);
        check("ready after delay", dsp_ready, 1);
        rd(16'h000E);
        check("status ready data", data_out, 16'h0080);
        check("status ready valid", valid, 1);
        idle(1);
        check("valid one cycle", valid, 0);
        check("data zero idle", data_out, 16'h0000);
        rd(16'h000A);
        check("read AA", data_out, 16'h00AA);
        check("read AA valid", valid, 1);
        check("ready cleared", dsp_ready, 0);
        rd(16'h000E);
        check("status after read", data_out, 16'h0000);
        check("status after valid", valid, 1);
        rd(16'h000A);
        check("repeat read AA", data_out, 16'h00AA);
        rd(16'h0008);
        check("unmapped valid", valid, 0);
        check("unmapped data", data_out, 16'h0000);
        wr(16'h0006, 16'h0000);
        rd(16'h000A);
        check("write0 outside held", data_out, 16'h00AA);

        // Short pulse
        wr(16'h0006, 16'h0001);
        idle(5);
        wr(16'h0006, 16'h0000);
`ifdef DSP_PULSE_CHECK_EN
        check("short pulse err", pulse_err, 1);
        idle(4);
        rd(16'h000E);
        check("short status", data_out, 16'h0000);
        idle(40);
        rd(16'h000E);
        check("short status late", data_out, 16'h0000);
        check("short ready", dsp_ready, 0);
        full_pulse(16'h0006);
        check("accept clears err", pulse_err, 0);
        wr(16'h0006, 16'h0001);
        idle(20);
        wr(16'h0006, 16'h0001);
        idle(10);
        wr(16'h0006, 16'h0000);
        check("restart err", pulse_err, 1);
`else
        check("short pulse no err", pulse_err, 0);
        idle(4);
        check("short ready", dsp_ready, 1);
        rd(16'h000E);
        check("short status", data_out, 16'h0080);
`endif

        // Reset write while response is pending
        full_pulse(16'h0006);
        check("pending ready", dsp_ready, 1);
        wr(16'h0006, 16'h0001);
        check("rewrite clears ready", dsp_ready, 0);
        rd(16'h000E);
        check("held status", data_out, 16'h0000);

        // Bus reset during RESP_WAIT, with a read on the bus
        idle(30);
        wr(16'h0006, 16'h0000);
        idle(2);
        reset   = 1'b1;
        address = 16'h000E;
        rd_en   = 1'b1;
        idle(1);
        reset   = 1'b0;
        rd_en   = 1'b0;
        check("reset ovr valid", valid, 0);
        check("reset ovr ready", dsp_ready, 0);
        check("reset ovr err", pulse_err, 0);
        idle(6);
        rd(16'h000E);
        check("post reset status", data_out, 16'h0000);
        check("post reset valid", valid, 1);
        check("post reset ready", dsp_ready, 0);

        // Write and read together: read ignored, DATA_READY not consumed
        full_pulse(16'h0006);
        address = 16'h000A;
        data_in = 16'h0000;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        idle(1);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("wr+rd valid", valid, 0);
        check("wr+rd data", data_out, 16'h0000);
        check("wr+rd ready kept", dsp_ready, 1);

        // Relocated block
        full_pulse(16'h0226);
        check("base2 ready", dsp_ready2, 1);
        check("base0 unaffected", dsp_ready, 1);
        rd(16'h022E);
        check("base2 status", data_out2, 16'h0080);
        check("base2 status valid", valid2, 1);
        check("base0 no decode", valid, 0);
        rd(16'h0231);
        check("base2 unmapped valid", valid2, 0);
        check("base2 unmapped data", data_out2, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sb_dsp_reset_responder.md
SB_DSP_RESET_RESPONDER -- requirements
Module: sb_dsp_reset_responder

Interface
REQ-001 Parameter BASE_ADDRESS, default 16'h0000, I/O base of the emulated DSP port block.
REQ-002 Parameter MIN_PULSE_CYCLES, default 24, minimum reset-high time in bus_clock cycles (3 us at 8 MHz).
REQ-003 Parameter RESP_DELAY_CYCLES, default 4, cycles from accepted reset release to 0xAA availability.
REQ-004 bus_clock  input  1  bus clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 address  input  16  bus address, sampled when wr_en or rd_en is high.
REQ-007 data_in  input  16  write data, sampled when wr_en is high.
REQ-008 wr_en  input  1  one-cycle write qualifier.
REQ-009 rd_en  input  1  one-cycle read qualifier.
REQ-010 data_out  output  16  registered read data.
REQ-011 data_out_valid  output  1  high for exactly one cycle when data_out carries a mapped read response.
REQ-012 dsp_ready  output  1  high while 0xAA is pending in the read port (status bit 7).
REQ-013 pulse_err  output  1  sticky flag: a reset pulse shorter than MIN_PULSE_CYCLES was rejected.

Function
REQ-014 Ports: RESET = BASE+6 (write), STATUS = BASE+E (read), READ = BASE+A (read); all other addresses unmapped.
REQ-015 States: IDLE, RESET_HELD, RESP_WAIT, DATA_READY, READY.
REQ-016 Any state: wr_en to RESET with data_in[0]=1 -> RESET_HELD, pulse counter cleared to 0, dsp_ready cleared.
REQ-017 RESET_HELD: pulse counter increments each cycle, saturating at MIN_PULSE_CYCLES; a repeated write of 1 restarts it at 0.
REQ-018 RESET_HELD: wr_en to RESET with data_in[0]=0 and counter >= MIN_PULSE_CYCLES -> RESP_WAIT, delay counter cleared.
REQ-019 RESET_HELD: write of 0 with counter < MIN_PULSE_CYCLES -> IDLE, pulse_err set.
REQ-020 Writes of 0 to RESET outside RESET_HELD: no effect.
REQ-021 RESP_WAIT: after RESP_DELAY_CYCLES cycles -> DATA_READY; dsp_ready high from the first DATA_READY cycle.
REQ-022 STATUS read: data_out = 16'h0080 in DATA_READY, 16'h0000 otherwise; no state change.
REQ-023 READ read in DATA_READY: data_out = 16'h00AA, -> READY, dsp_ready low from next cycle.
REQ-024 READ read in READY: data_out = 16'h00AA; any other state: 16'h0000.
REQ-025 Read latency: data_out/data_out_valid valid the cycle after rd_en; unmapped reads give data_out_valid=0, data_out=16'h0000.
REQ-026 wr_en and rd_en both high: write processed, read ignored (no data_out_valid).
REQ-027 data_out holds 16'h0000 whenever data_out_valid is low.
REQ-028 pulse_err cleared only by reset or by an accepted reset release (REQ-018).

Reset
REQ-029 reset high at a rising edge: state IDLE, both counters 0, data_out 16'h0000, data_out_valid 0, dsp_ready 0, pulse_err 0.
REQ-030 reset overrides every bus input in the same cycle, including mid-pulse and mid-RESP_WAIT.

Configuration
REQ-031 Macro DSP_PULSE_CHECK_EN defined: minimum-pulse check per REQ-017 to REQ-019.
REQ-032 Macro undefined: any write of 0 in RESET_HELD -> RESP_WAIT regardless of counter; pulse counter omitted; pulse_err tied 0.

Verification
REQ-033 Write 1 to 16'h0006, idle 30 cycles, write 0, wait 4 cycles, read 16'h000E -> data_out 16'h0080 valid next cycle, dsp_ready 1.
REQ-034 After REQ-033, read 16'h000A -> 16'h00AA; next STATUS read -> 16'h0000, dsp_ready 0; repeat READ -> 16'h00AA.
REQ-035 Write 1, write 0 after 5 cycles (macro defined) -> pulse_err 1, STATUS reads 16'h0000 indefinitely; undefined -> 16'h0080 after 4 cycles.
REQ-036 Assert reset during RESP_WAIT -> next cycle IDLE, STATUS read returns 16'h0000, dsp_ready 0.
REQ-037 BASE_ADDRESS=16'h0220: write 1 to 16'h0226 accepted; read of 16'h0231 -> data_out_valid 0; simultaneous wr_en/rd_en -> no data_out_valid.
